instruction_fetch: RTL

Consumer side of the program counter: samples the current `pc`, runs a request/acknowledge read on instruction memory, and presents the fetched word to decode with a valid/ready handshake. After each fetch it returns `PCWriteValue = fetched address + 4` and a one-cycle `PCWrite` pulse. It sits between the program counter, the instruction memory port and the decode stage. It discards in-flight fetches on a control-flow flush.

---
 rtl/instruction_fetch_if.sv | 19 +
 rtl/instruction_fetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory read port and decode-facing handshake
interface instruction_fetch_if;
    logic [31:0] memAddr;
    logic        memReq;
    logic        memAck;
    logic [31:0] memRdata;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic        instrValid;
    logic        instrReady;
    modport master (
        output memAddr, memReq, instr, instrPC, instrValid,
        input  memAck, memRdata, instrReady
    );
    modport slave (
        input  memAddr, memReq, instr, instrPC, instrValid,
        output memAck, memRdata, instrReady
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches the word at pc over a req/ack memory port and hands it to decode
module instruction_fetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                pc,
    input  logic                       fetchEn,
    input  logic                       flush,
    instruction_fetch_if.master        bus,
    output logic [31:0]                PCWriteValue,
    output logic                       PCWrite,
    output logic                       fetchFault
);
    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;
    state_t      state, state_n;
    logic [31:0] mem_addr, addr_n, instr_q, instr_n, instr_pc, ipc_n, pcwv_n;
    logic        mem_req, req_n, instr_valid, valid_n, pcw_n, fault_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic        tmo;
    assign cnt_inc = cnt + 16'd1;
    assign tmo = cnt_inc == 16'(ACK_TIMEOUT);
    assign bus.memAddr = mem_addr;
    assign bus.memReq = mem_req;
    assign bus.instr = instr_q;
    assign bus.instrPC = instr_pc;
    assign bus.instrValid = instr_valid;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            mem_addr     <= '0;
            mem_req      <= 1'b0;
            instr_q      <= RESET_INSTR;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            PCWriteValue <= '0;
            PCWrite      <= 1'b0;
            fetchFault   <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            mem_addr     <= addr_n;
            mem_req      <= req_n;
            instr_q      <= instr_n;
            instr_pc     <= ipc_n;
            instr_valid  <= valid_n;
            PCWriteValue <= pcwv_n;
            PCWrite      <= pcw_n;
            fetchFault   <= fault_n;
            cnt          <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        addr_n  = mem_addr;
        req_n   = mem_req;
        instr_n = instr_q;
        ipc_n   = instr_pc;
        valid_n = instr_valid;
        pcwv_n  = PCWriteValue;
        pcw_n   = 1'b0;
        fault_n = fetchFault;
        cnt_n   = (state == REQ || state == DROP) ? cnt_inc : '0;
        case (state)
            IDLE: begin
                if (flush) begin
                    fault_n = 1'b0;
                end else if (fetchEn && !fetchFault) begin
                    if (pc[1:0] != 2'b00) begin
                        fault_n = 1'b1;
                    end else begin
                        addr_n  = pc;
                        req_n   = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.memAck) begin
                    req_n   = 1'b0;
                    state_n = flush ? IDLE : HOLD;
                    if (!flush) begin
                        instr_n = bus.memRdata;
                        ipc_n   = mem_addr;
                        valid_n = 1'b1;
                        pcwv_n  = mem_addr + 32'd4;
                        pcw_n   = 1'b1;
                    end
                end else if (flush) begin
                    // request stays asserted; the ack is swallowed in DROP
                    state_n = DROP;
                    cnt_n   = '0;
                end else if (tmo) begin
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (bus.memAck) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (tmo) begin
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (flush || bus.instrReady) begin
                    valid_n = 1'b0;
                    instr_n = flush ? RESET_INSTR : instr_q;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
